// File: rtl/sisc_rf_sb.sv
// sisc_rf_sb: register file with per-register pending scoreboard for in-order issue.
// Define SISC_RF_BYPASS_EN to forward same-cycle writeback data to read ports and mask their stall.
module sisc_rf_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic [ADDR_W-1:0] rsa_addr,
    input  logic [ADDR_W-1:0] rsb_addr,
    output logic [DATA_W-1:0] rsa_data,
    output logic [DATA_W-1:0] rsb_data,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rf_we,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_ready,
    output logic              stall,
    output logic [ADDR_W:0]   pend_cnt
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic              set_en, byp_a, byp_b;

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < DEPTH; i++) pend_cnt = pend_cnt + (ADDR_W+1)'(pend_q[i]);
    end

    assign issue_ready = (issue_rd == '0) || (!pend_q[issue_rd] && pend_cnt < (ADDR_W+1)'(DEPTH - 1));
    assign set_en      = issue_valid && issue_ready && issue_rd != '0;

    // set is applied after clear so a same-edge issue of the written register wins
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (rf_we && wr_addr != '0) mem_d[wr_addr] = wr_data;
        if (rf_we) pend_d[wr_addr] = 1'b0;
        if (set_en) pend_d[issue_rd] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

`ifdef SISC_RF_BYPASS_EN
    assign byp_a = rst_f && rf_we && rsa_addr != '0 && wr_addr == rsa_addr;
    assign byp_b = rst_f && rf_we && rsb_addr != '0 && wr_addr == rsb_addr;
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif

    assign rsa_data = byp_a ? wr_data : mem_q[rsa_addr];
    assign rsb_data = byp_b ? wr_data : mem_q[rsb_addr];
    assign stall    = (pend_q[rsa_addr] && !byp_a) || (pend_q[rsb_addr] && !byp_b);
endmodule

// File: tb/tb_sisc_rf_sb.sv
// tb_sisc_rf_sb: directed scenarios plus randomized traffic checked against an array/count reference model.
module tb_sisc_rf_sb;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst_f;
    logic [AW-1:0] rsa_addr, rsb_addr, wr_addr, issue_rd;
    logic [DW-1:0] rsa_data, rsb_data, wr_data;
    logic          rf_we, issue_valid, issue_ready, stall;
    logic [AW:0]   pend_cnt;

    int n_chk = 0;
    int n_fail = 0;

    logic [DW-1:0] m_mem [DEPTH];
    bit            m_pend [DEPTH];

    sisc_rf_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_f(rst_f),
        .rsa_addr(rsa_addr), .rsb_addr(rsb_addr),
        .rsa_data(rsa_data), .rsb_data(rsb_data),
        .wr_addr(wr_addr), .wr_data(wr_data), .rf_we(rf_we),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .stall(stall), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    function automatic bit m_ready(int rd);
        return rd == 0 || (!m_pend[rd] && m_cnt() < DEPTH - 1);
    endfunction

    function automatic bit m_byp(int a);
`ifdef SISC_RF_BYPASS_EN
        return rf_we && a != 0 && int'(wr_addr) == a;
`else
        return a < 0;
`endif
    endfunction

    function automatic logic [DW-1:0] m_read(int a);
        return a == 0 ? '0 : (m_byp(a) ? wr_data : m_mem[a]);
    endfunction

    function automatic bit m_stall();
        return (m_pend[rsa_addr] && !m_byp(int'(rsa_addr))) || (m_pend[rsb_addr] && !m_byp(int'(rsb_addr)));
    endfunction

    task automatic m_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic idle();
        rf_we = 1'b0;
        issue_valid = 1'b0;
    endtask

    task automatic tick();
        bit s;
        s = issue_valid && issue_rd != '0 && m_ready(int'(issue_rd));
        @(posedge clk);
        if (rf_we && wr_addr != '0) m_mem[wr_addr] = wr_data;
        if (rf_we) m_pend[wr_addr] = 1'b0;
        if (s) m_pend[issue_rd] = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        rst_f = 1'b0;
        #1;
        rst_f = 1'b1;
        m_clear();
        #1;
    endtask

    task automatic test_reset();
        rst_f = 1'b0;
        rf_we = 1'b1; wr_addr = 4'd3; wr_data = 32'hCAFEF00D;
        issue_valid = 1'b1; issue_rd = 4'd5;
        rsa_addr = 4'd3; rsb_addr = 4'd5;
        repeat (2) @(posedge clk);
        #2;
        n_chk++; if (rsa_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsa: got %h want %h", rsa_data, 32'h0); end
        n_chk++; if (rsb_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsb: got %h want %h", rsb_data, 32'h0); end
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_chk++; if (pend_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", pend_cnt); end
        n_chk++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", issue_ready); end
        idle();
        @(negedge clk);
        rst_f = 1'b1;
        m_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reservation();
        idle();
        issue_valid = 1'b1; issue_rd = 4'd5;
        #2;
        n_chk++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL resv_ready1: got %b want 1", issue_ready); end
        tick();
        idle();
        rsa_addr = 4'd5; rsb_addr = 4'd0;
        #2;
        n_chk++; if (pend_cnt !== 5'd1) begin n_fail++; $display("FAIL resv_cnt1: got %0d want 1", pend_cnt); end
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL resv_stall1: got %b want 1", stall); end
        issue_valid = 1'b1; issue_rd = 4'd5;
        #1;
        n_chk++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL resv_ready2: got %b want 0", issue_ready); end
        tick();
        idle();
        #1;
        n_chk++; if (pend_cnt !== 5'd1) begin n_fail++; $display("FAIL resv_hold_cnt: got %0d want 1", pend_cnt); end
        rf_we = 1'b1; wr_addr = 4'd5; wr_data = 32'h12;
        tick();
        idle();
        #2;
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL resv_stall0: got %b want 0", stall); end
        n_chk++; if (pend_cnt !== 5'd0) begin n_fail++; $display("FAIL resv_cnt0: got %0d want 0", pend_cnt); end
        n_chk++; if (rsa_data !== 32'h12) begin n_fail++; $display("FAIL resv_data: got %h want %h", rsa_data, 32'h12); end
    endtask

    task automatic test_r0();
        issue_valid = 1'b1; issue_rd = 4'd0;
        rf_we = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFFFFFF;
        rsa_addr = 4'd0; rsb_addr = 4'd0;
        #2;
        n_chk++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL r0_ready: got %b want 1", issue_ready); end
        n_chk++; if (rsa_data !== 32'h0) begin n_fail++; $display("FAIL r0_comb_read: got %h want 0", rsa_data); end
        tick();
        idle();
        #2;
        n_chk++; if (pend_cnt !== 5'd0) begin n_fail++; $display("FAIL r0_cnt: got %0d want 0", pend_cnt); end
        n_chk++; if (rsb_data !== 32'h0) begin n_fail++; $display("FAIL r0_read: got %h want 0", rsb_data); end
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall: got %b want 0", stall); end
    endtask

    task automatic test_same_edge();
        issue_valid = 1'b1; issue_rd = 4'd7;
        rf_we = 1'b1; wr_addr = 4'd7; wr_data = 32'h55;
        tick();
        idle();
        rsa_addr = 4'd7; rsb_addr = 4'd0;
        #2;
        n_chk++; if (rsa_data !== 32'h55) begin n_fail++; $display("FAIL same_data: got %h want %h", rsa_data, 32'h55); end
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL same_pend: got %b want 1", stall); end
        n_chk++; if (pend_cnt !== 5'd1) begin n_fail++; $display("FAIL same_cnt: got %0d want 1", pend_cnt); end
        // one register set while another clears: net count unchanged
        issue_valid = 1'b1; issue_rd = 4'd8;
        rf_we = 1'b1; wr_addr = 4'd7; wr_data = 32'h56;
        tick();
        idle();
        #2;
        n_chk++; if (pend_cnt !== 5'd1) begin n_fail++; $display("FAIL swap_cnt: got %0d want 1", pend_cnt); end
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL swap_stall: got %b want 0", stall); end
        rf_we = 1'b1; wr_addr = 4'd8; wr_data = 32'h0;
        tick();
        idle();
    endtask

    task automatic test_bypass();
        logic [DW-1:0] old_v, exp_d;
        bit exp_s;
        issue_valid = 1'b1; issue_rd = 4'd2;
        tick();
        idle();
        rsa_addr = 4'd0; rsb_addr = 4'd2;
        old_v = m_mem[2];
        rf_we = 1'b1; wr_addr = 4'd2; wr_data = 32'hA5A5A5A5;
        #2;
`ifdef SISC_RF_BYPASS_EN
        exp_d = 32'hA5A5A5A5; exp_s = 1'b0;
`else
        exp_d = old_v; exp_s = 1'b1;
`endif
        n_chk++; if (rsb_data !== exp_d) begin n_fail++; $display("FAIL byp_data: got %h want %h", rsb_data, exp_d); end
        n_chk++; if (stall !== exp_s) begin n_fail++; $display("FAIL byp_stall: got %b want %b", stall, exp_s); end
        tick();
        idle();
        #2;
        n_chk++; if (rsb_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL byp_after: got %h want %h", rsb_data, 32'hA5A5A5A5); end
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL byp_after_stall: got %b want 0", stall); end
    endtask

    task automatic test_full();
        do_reset();
        idle();
        for (int r = 1; r < DEPTH; r++) begin
            issue_valid = 1'b1; issue_rd = AW'(r);
            #2;
            n_chk++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL full_fill_ready r%0d: got %b want 1", r, issue_ready); end
            tick();
        end
        idle();
        #1;
        n_chk++; if (pend_cnt !== 5'd15) begin n_fail++; $display("FAIL full_cnt: got %0d want 15", pend_cnt); end
        for (int r = 1; r < DEPTH; r++) begin
            issue_rd = AW'(r);
            #1;
            n_chk++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready r%0d: got %b want 0", r, issue_ready); end
        end
        issue_rd = 4'd0;
        #1;
        n_chk++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_r0: got %b want 1", issue_ready); end
        rf_we = 1'b1; wr_addr = 4'd9; wr_data = 32'h99;
        tick();
        idle();
        issue_rd = 4'd9;
        #1;
        n_chk++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_r9: got %b want 1", issue_ready); end
        n_chk++; if (pend_cnt !== 5'd14) begin n_fail++; $display("FAIL full_cnt14: got %0d want 14", pend_cnt); end
        issue_rd = 4'd10;
        #1;
        n_chk++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_r10: got %b want 0", issue_ready); end
    endtask

    task automatic test_random();
        logic [DW-1:0] ea, eb;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rsa_addr = AW'($urandom_range(0, DEPTH - 1));
            rsb_addr = AW'($urandom_range(0, DEPTH - 1));
            wr_addr = AW'($urandom_range(0, DEPTH - 1));
            wr_data = $urandom;
            rf_we = ($urandom_range(0, 99) < 40);
            issue_valid = ($urandom_range(0, 99) < 70);
            issue_rd = AW'($urandom_range(0, DEPTH - 1));
            #2;
            ea = m_read(int'(rsa_addr));
            eb = m_read(int'(rsb_addr));
            n_chk++; if (rsa_data !== ea) begin n_fail++; $display("FAIL rnd_rsa @%0d: got %h want %h", n, rsa_data, ea); end
            n_chk++; if (rsb_data !== eb) begin n_fail++; $display("FAIL rnd_rsb @%0d: got %h want %h", n, rsb_data, eb); end
            n_chk++; if (stall !== m_stall()) begin n_fail++; $display("FAIL rnd_stall @%0d: got %b want %b", n, stall, m_stall()); end
            n_chk++; if (pend_cnt !== 5'(m_cnt())) begin n_fail++; $display("FAIL rnd_cnt @%0d: got %0d want %0d", n, pend_cnt, m_cnt()); end
            n_chk++; if (issue_ready !== m_ready(int'(issue_rd))) begin n_fail++; $display("FAIL rnd_ready @%0d: got %b want %b", n, issue_ready, m_ready(int'(issue_rd))); end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        rf_we = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF;
        issue_valid = 1'b1; issue_rd = 4'd6;
        tick();
        idle();
        rsa_addr = 4'd3; rsb_addr = 4'd6;
        #1;
        n_chk++; if (rsa_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mid_pre: got %h want %h", rsa_data, 32'hDEADBEEF); end
        rst_f = 1'b0;
        #1;
        n_chk++; if (rsa_data !== 32'h0) begin n_fail++; $display("FAIL mid_rsa: got %h want 0", rsa_data); end
        n_chk++; if (pend_cnt !== 5'd0) begin n_fail++; $display("FAIL mid_cnt: got %0d want 0", pend_cnt); end
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mid_stall: got %b want 0", stall); end
        rst_f = 1'b1;
        m_clear();
        issue_valid = 1'b1; issue_rd = 4'd4;
        tick();
        idle();
        #1;
        n_chk++; if (pend_cnt !== 5'd1) begin n_fail++; $display("FAIL mid_cold_cnt: got %0d want 1", pend_cnt); end
    endtask

    initial begin
        rst_f = 1'b0;
        rsa_addr = '0; rsb_addr = '0; wr_addr = '0; wr_data = '0; issue_rd = '0;
        idle();
        m_clear();
        test_reset();
        test_reservation();
        test_r0();
        test_same_edge();
        test_bypass();
        test_full();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
